// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
//   state_t      : loader FSM states
//   ACK_BYTE     : reply sent after a complete load ('O')
//   NAK_BYTE     : reply sent after an aborted load ('E')
//   SEG_IMEM/DMEM: segment select carried in upg_adr_o[14]
//   insert_byte  : places one received byte into its lane of a 32-bit word
package loader_pkg;

    typedef enum logic [2:0] {
        CNT_LO   = 3'd0,
        CNT_HI   = 3'd1,
        WORD     = 3'd2,
        WRITE    = 3'd3,
        NEXT_SEG = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [7:0] ACK_BYTE = 8'h4F;
    localparam logic [7:0] NAK_BYTE = 8'h45;

    localparam logic SEG_IMEM = 1'b0;
    localparam logic SEG_DMEM = 1'b1;

    // Words arrive little-endian, so byte lane idx holds bits idx*8 +: 8.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (idx)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w        = word;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Memory-programming port driven by the loader.
//   upg_clk_o  : memory write clock (same as the loader clock)
//   upg_wen_o  : one-cycle write strobe
//   upg_adr_o  : {segment, 14-bit word index}
//   upg_dat_o  : word to write
//   upg_done_o : load complete, sticky until reset
// master = loader side, slave = memory side.
interface uart_prog_loader_if;

    logic        upg_clk_o;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;

    modport master (
        output upg_clk_o,
        output upg_wen_o,
        output upg_adr_o,
        output upg_dat_o,
        output upg_done_o
    );

    modport slave (
        input upg_clk_o,
        input upg_wen_o,
        input upg_adr_o,
        input upg_dat_o,
        input upg_done_o
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clock, reset : system clock, synchronous active-high reset
//   rx_i         : asynchronous serial line, idles high
//   data         : last received byte (valid while byte_valid is high)
//   byte_valid   : 1-cycle pulse, one clock after a good stop-bit sample
//   frame_err    : 1-cycle pulse, one clock after a low stop-bit sample
//   start_seen   : 1-cycle pulse when a start bit survives the mid-bit check
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 78
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       start_seen
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t        rx_state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic             byte_valid_r;
    logic             frame_err_r;
    logic             start_seen_r;

    // Synchronizer, edge detect, bit timing and sampling.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_r   <= RX_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            start_seen_r <= 1'b0;
        end else begin
            rx_meta_r    <= rx_i;
            rx_sync_r    <= rx_meta_r;
            rx_prev_r    <= rx_sync_r;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            start_seen_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    cnt_r <= '0;
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_M1) begin
                        cnt_r <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        if (rx_sync_r) begin
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_state_r   <= RX_DATA;
                            bit_idx_r    <= 3'd0;
                            start_seen_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r   <= '0;
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r        <= '0;
                        rx_state_r   <= RX_IDLE;
                        byte_valid_r <= rx_sync_r;
                        frame_err_r  <= !rx_sync_r;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    cnt_r      <= '0;
                end
            endcase
        end
    end

    assign data       = shift_r;
    assign byte_valid = byte_valid_r;
    assign frame_err  = frame_err_r;
    assign start_seen = start_seen_r;

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot-image loader for the single-cycle CPU.
// Receives two segments (imem, then dmem), each a 16-bit little-endian word
// count followed by that many little-endian 32-bit words, writes every word
// through the upg port and answers with 'O' (loaded) or 'E' (aborted).
//   clock, reset : system clock, synchronous active-high reset
//   rx_i         : UART receive line
//   tx_o         : UART transmit line (status reply)
//   upg          : memory-programming port (master side)
//   err_o        : load aborted, sticky until reset
//   busy_o       : load in progress (first start bit until DONE/ERR)
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ       = 10_000_000,
    parameter int BAUD         = 128_000,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int MAX_WORDS    = 16384
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rx_i,
    output logic                       tx_o,
    uart_prog_loader_if.master         upg,
    output logic                       err_o,
    output logic                       busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [7:0]  rx_data_s;
    logic        byte_valid_s;
    logic        frame_err_s;
    logic        start_seen_s;
    logic [15:0] n_s;
    logic [31:0] word_next_s;
    logic        last_word_s;
    logic        terminal_s;

    state_t      state_r;
    logic        seg_r;
    logic [13:0] index_r;
    logic [7:0]  count_lo_r;
    logic [15:0] count_r;
    logic [31:0] word_r;
    logic [1:0]  byte_idx_r;
    logic        upg_wen_r;
    logic [14:0] upg_adr_r;
    logic [31:0] upg_dat_r;
    logic        upg_done_r;
    logic        err_r;
    logic        busy_r;
    logic        tx_start_r;
    logic [7:0]  tx_byte_r;

    logic             tx_o_r;
    logic             tx_active_r;
    logic [8:0]       tx_shift_r;
    logic [3:0]       tx_bits_r;
    logic [CNT_W-1:0] tx_cnt_r;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx_i       (rx_i),
        .data       (rx_data_s),
        .byte_valid (byte_valid_s),
        .frame_err  (frame_err_s),
        .start_seen (start_seen_s)
    );

    assign n_s         = {rx_data_s, count_lo_r};
    assign word_next_s = insert_byte(word_r, byte_idx_r, rx_data_s);
    assign last_word_s = ({2'b00, index_r} == (count_r - 16'd1));
    assign terminal_s  = (state_r == DONE) || (state_r == ERR);

    // Loader FSM: count parsing, word assembly, write strobes, completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= CNT_LO;
            seg_r      <= SEG_IMEM;
            index_r    <= 14'd0;
            count_lo_r <= 8'h00;
            count_r    <= 16'd0;
            word_r     <= 32'h0000_0000;
            byte_idx_r <= 2'd0;
            upg_wen_r  <= 1'b0;
            upg_adr_r  <= 15'd0;
            upg_dat_r  <= 32'h0000_0000;
            upg_done_r <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            tx_start_r <= 1'b0;
            tx_byte_r  <= 8'h00;
        end else begin
            upg_wen_r  <= 1'b0;
            tx_start_r <= 1'b0;
            if (start_seen_s && !terminal_s) begin
                busy_r <= 1'b1;
            end
            // A framing error outranks any byte and aborts the whole load.
            if (frame_err_s && !terminal_s) begin
                state_r    <= ERR;
                err_r      <= 1'b1;
                busy_r     <= 1'b0;
                tx_start_r <= 1'b1;
                tx_byte_r  <= NAK_BYTE;
            end else begin
                case (state_r)
                    CNT_LO: begin
                        if (byte_valid_s) begin
                            count_lo_r <= rx_data_s;
                            state_r    <= CNT_HI;
                        end
                    end
                    CNT_HI: begin
                        if (byte_valid_s) begin
                            count_r <= n_s;
                            if ({1'b0, n_s} > 17'(MAX_WORDS)) begin
                                state_r    <= ERR;
                                err_r      <= 1'b1;
                                busy_r     <= 1'b0;
                                tx_start_r <= 1'b1;
                                tx_byte_r  <= NAK_BYTE;
                            end else if (n_s == 16'd0) begin
                                state_r <= NEXT_SEG;
                            end else begin
                                state_r    <= WORD;
                                byte_idx_r <= 2'd0;
                                word_r     <= 32'h0000_0000;
                            end
                        end
                    end
                    WORD: begin
                        if (byte_valid_s) begin
                            word_r <= word_next_s;
                            // Strobe is registered here so it appears in the WRITE cycle.
                            if (byte_idx_r == 2'd3) begin
                                state_r   <= WRITE;
                                upg_wen_r <= 1'b1;
                                upg_adr_r <= {seg_r, index_r};
                                upg_dat_r <= word_next_s;
                            end else begin
                                byte_idx_r <= byte_idx_r + 2'd1;
                            end
                        end
                    end
                    WRITE: begin
                        if (last_word_s) begin
                            state_r <= NEXT_SEG;
                        end else begin
                            index_r    <= index_r + 14'd1;
                            byte_idx_r <= 2'd0;
                            state_r    <= WORD;
                        end
                    end
                    NEXT_SEG: begin
                        if (seg_r == SEG_IMEM) begin
                            seg_r   <= SEG_DMEM;
                            index_r <= 14'd0;
                            state_r <= CNT_LO;
                        end else begin
                            state_r    <= DONE;
                            upg_done_r <= 1'b1;
                            busy_r     <= 1'b0;
                            tx_start_r <= 1'b1;
                            tx_byte_r  <= ACK_BYTE;
                        end
                    end
                    DONE: begin
                        state_r <= DONE;
                    end
                    ERR: begin
                        state_r <= ERR;
                    end
                    default: begin
                        state_r <= ERR;
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Reply serializer: start bit, 8 data bits LSB-first, stop bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_o_r      <= 1'b1;
            tx_active_r <= 1'b0;
            tx_shift_r  <= 9'h1FF;
            tx_bits_r   <= 4'd0;
            tx_cnt_r    <= '0;
        end else if (tx_start_r) begin
            tx_o_r      <= 1'b0;
            tx_active_r <= 1'b1;
            tx_shift_r  <= {1'b1, tx_byte_r};
            tx_bits_r   <= 4'd9;
            tx_cnt_r    <= '0;
        end else if (tx_active_r) begin
            if (tx_cnt_r == FULL_M1) begin
                tx_cnt_r <= '0;
                if (tx_bits_r == 4'd0) begin
                    tx_active_r <= 1'b0;
                    tx_o_r      <= 1'b1;
                end else begin
                    tx_o_r     <= tx_shift_r[0];
                    tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                    tx_bits_r  <= tx_bits_r - 4'd1;
                end
            end else begin
                tx_cnt_r <= tx_cnt_r + 1'b1;
            end
        end else begin
            tx_o_r <= 1'b1;
        end
    end

    assign tx_o           = tx_o_r;
    assign err_o          = err_r;
    assign busy_o         = busy_r;
    assign upg.upg_clk_o  = clock;
    assign upg.upg_wen_o  = upg_wen_r;
    assign upg.upg_adr_o  = upg_adr_r;
    assign upg.upg_dat_o  = upg_dat_r;
    assign upg.upg_done_o = upg_done_r;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: images are parsed by a reference
// model into expected writes and reply bytes; monitors compare the DUT's
// strobes and serial reply against those queues.
module tb_uart_prog_loader;

    localparam int CPB  = 78;
    localparam int MAXW = 16384;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx_i  = 1'b1;
    wire  tx_o;
    wire  err_o;
    wire  busy_o;

    uart_prog_loader_if upg_if ();

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .MAX_WORDS    (MAXW)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .rx_i   (rx_i),
        .tx_o   (tx_o),
        .upg    (upg_if.master),
        .err_o  (err_o),
        .busy_o (busy_o)
    );

    always #50 clock = ~clock;

    int checks = 0;
    int passed = 0;

    logic [14:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [7:0]  exp_reply_q[$];
    logic        exp_done;
    logic        exp_err;
    logic [14:0] last_adr;
    logic [31:0] last_dat;
    bit          any_wr;
    longint      cyc     = 0;
    longint      last_bv = -10;
    int          bv_count = 0;
    logic        prev_wen = 1'b0;
    logic [7:0]  rb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Write-strobe monitor
    initial forever begin
        @(negedge clock);
        cyc++;
        if (reset) begin
            prev_wen = 1'b0;
        end else begin
            if (dut.u_rx.byte_valid) begin
                last_bv = cyc;
                bv_count++;
            end
            if (upg_if.upg_wen_o) begin
                check("wen_single_cycle", {31'd0, prev_wen}, 32'd0);
                check("write_latency", 32'(cyc - last_bv), 32'd1);
                if (exp_adr_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_strobe: got strobe adr 0x%0h, expected none", upg_if.upg_adr_o);
                end else begin
                    check("write_adr", {17'd0, upg_if.upg_adr_o}, {17'd0, exp_adr_q.pop_front()});
                    check("write_dat", upg_if.upg_dat_o, exp_dat_q.pop_front());
                end
            end
            prev_wen = upg_if.upg_wen_o;
        end
    end

    // Reply monitor: decodes the serial byte on tx_o
    initial forever begin
        @(negedge clock);
        if (!reset && tx_o === 1'b0) begin
            repeat (CPB / 2) @(negedge clock);
            check("tx_start_bit", {31'd0, tx_o}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clock);
                rb[i] = tx_o;
            end
            repeat (CPB) @(negedge clock);
            check("tx_stop_bit", {31'd0, tx_o}, 32'd1);
            if (exp_reply_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_reply: got 0x%0h, expected none", rb);
            end else begin
                check("tx_reply", {24'd0, rb}, {24'd0, exp_reply_q.pop_front()});
            end
        end
    end

    initial begin
        #9_500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Reference model: parse the byte stream (truncated at a framing error).
    task automatic model(input logic [7:0] b[$], input int bad);
        int lim, p, n;
        bit stalled, err;
        logic [31:0] w;
        lim = (bad >= 0 && bad < b.size()) ? bad : b.size();
        p = 0; stalled = 0; err = 0;
        for (int s = 0; s < 2; s++) begin
            if (p + 2 > lim) begin stalled = 1; break; end
            n = int'(b[p]) + 256 * int'(b[p+1]);
            p += 2;
            if (n > MAXW) begin err = 1; break; end
            for (int i = 0; i < n; i++) begin
                if (p + 4 > lim) begin stalled = 1; break; end
                w = {b[p+3], b[p+2], b[p+1], b[p]};
                p += 4;
                exp_adr_q.push_back({s[0], i[13:0]});
                exp_dat_q.push_back(w);
                any_wr   = 1;
                last_adr = {s[0], i[13:0]};
                last_dat = w;
            end
            if (stalled) break;
        end
        if (stalled && lim < b.size()) err = 1;
        exp_err  = err;
        exp_done = !err && !stalled;
        if (err) exp_reply_q.push_back(8'h45);
        else if (exp_done) exp_reply_q.push_back(8'h4F);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx_i = stop;
        repeat (CPB) @(negedge clock);
        rx_i = 1'b1;
        repeat (2 + $urandom_range(0, 6)) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        rx_i  = 1'b1;
        repeat (3) @(negedge clock);
        exp_adr_q.delete();
        exp_dat_q.delete();
        exp_reply_q.delete();
        any_wr = 0;
        reset  = 1'b0;
        @(negedge clock);
    endtask

    task automatic finish_scenario();
        for (int k = 0; k < 3000 && exp_reply_q.size() != 0; k++) @(negedge clock);
        repeat (CPB) @(negedge clock);
        check("reply_outstanding", exp_reply_q.size(), 32'd0);
        check("writes_outstanding", exp_adr_q.size(), 32'd0);
        check("upg_done", {31'd0, upg_if.upg_done_o}, {31'd0, exp_done});
        check("err", {31'd0, err_o}, {31'd0, exp_err});
        check("busy_end", {31'd0, busy_o}, {31'd0, !(exp_done || exp_err)});
        check("tx_idle", {31'd0, tx_o}, 32'd1);
        if (any_wr) begin
            check("adr_held", {17'd0, upg_if.upg_adr_o}, {17'd0, last_adr});
            check("dat_held", upg_if.upg_dat_o, last_dat);
        end
        exp_reply_q.delete();
        exp_adr_q.delete();
        exp_dat_q.delete();
    endtask

    task automatic run_image(input logic [7:0] b[$], input int bad);
        model(b, bad);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], (i != bad));
            if (i == 0 && bad != 0) check("busy_during_load", {31'd0, busy_o}, 32'd1);
        end
        finish_scenario();
    endtask

    logic [7:0] img[$];
    int         bvc;
    int         ni, nd, bad;
    logic [31:0] rw;

    initial begin
        do_reset();
        check("rst_tx", {31'd0, tx_o}, 32'd1);
        check("rst_wen", {31'd0, upg_if.upg_wen_o}, 32'd0);
        check("rst_adr", {17'd0, upg_if.upg_adr_o}, 32'd0);
        check("rst_dat", upg_if.upg_dat_o, 32'd0);
        check("rst_done", {31'd0, upg_if.upg_done_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);

        // Nominal load
        img = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_image(img, -1);

        // Empty segments
        do_reset();
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_image(img, -1);

        // Framing error on the 3rd byte of an imem word; later bytes ignored
        do_reset();
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h55};
        run_image(img, 4);

        // Oversize imem count
        do_reset();
        img = '{8'h01, 8'h40};
        model(img, -1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h40, 1'b1);
        check("oversize_err_immediate", {31'd0, err_o}, 32'd1);
        finish_scenario();

        // Reset mid-word, then a full valid image
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        do_reset();
        img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00};
        run_image(img, -1);

        // Short low glitch while idle
        do_reset();
        bvc = bv_count;
        @(negedge clock);
        rx_i = 1'b0;
        repeat (20) @(negedge clock);
        rx_i = 1'b1;
        repeat (200) @(negedge clock);
        check("glitch_busy", {31'd0, busy_o}, 32'd0);
        check("glitch_no_byte", bv_count - bvc, 32'd0);
        check("glitch_err", {31'd0, err_o}, 32'd0);
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_image(img, -1);

        // Randomized images, occasionally with a framing error
        for (int r = 0; r < 2; r++) begin
            do_reset();
            img.delete();
            ni = $urandom_range(0, 2);
            nd = $urandom_range(0, 1);
            img.push_back(8'(ni));
            img.push_back(8'h00);
            for (int i = 0; i < ni; i++) begin
                rw = $urandom;
                for (int k = 0; k < 4; k++) img.push_back(rw[k*8 +: 8]);
            end
            img.push_back(8'(nd));
            img.push_back(8'h00);
            for (int i = 0; i < nd; i++) begin
                rw = $urandom;
                for (int k = 0; k < 4; k++) img.push_back(rw[k*8 +: 8]);
            end
            rw = $urandom;
            img.push_back(rw[7:0]);
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, img.size() - 1)) : -1;
            run_image(img, bad);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
